// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the branch/load-use hazard controller: FSM encoding,
// register-index constants, branch func3 codes and the control-word layout.
package branch_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
        logic pc_src;
    } hz_ctrl_t;

    // A redirect flushes through the stage registers, so their writes stay on.
    localparam hz_ctrl_t CTRL_INIT      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_RUN       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_REDIR_EX  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_REDIR_GO  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam hz_ctrl_t CTRL_REDIR_HLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_LU_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: EX/ID hazard sources in, stage enables out.
interface branch_hazard_ctrl_if #(
    parameter int XLEN = 32
);
    // No valid/ready pair here: every signal is level-sensitive and sampled each
    // cycle; mem_busy is the single global "not ready" that freezes the pipeline.
    logic            branch_taken_ex;
    logic            jump_ex;
    logic [XLEN-1:0] target_pc_ex;
    logic            memread_ex;
    logic [4:0]      rd_ex;
    logic [4:0]      rs1_id;
    logic [4:0]      rs2_id;
    logic            use_rs1_id;
    logic            use_rs2_id;
    logic            mem_busy;

    logic            pc_write;
    logic            ifid_write;
    logic            idex_write;
    logic            exmem_write;
    logic            ifid_flush;
    logic            idex_flush;
    logic            pc_src;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        input  branch_taken_ex, jump_ex, target_pc_ex, memread_ex, rd_ex,
               rs1_id, rs2_id, use_rs1_id, use_rs2_id, mem_busy,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, pc_src, redirect_pc
    );

    modport slave (
        output branch_taken_ex, jump_ex, target_pc_ex, memread_ex, rd_ex,
               rs1_id, rs2_id, use_rs1_id, use_rs2_id, mem_busy,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, pc_src, redirect_pc
    );
endinterface

// File: rtl/branch_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in EX feeds a register the ID instruction reads.
module load_use_detect
    import branch_hazard_ctrl_pkg::*;
(
    input  logic       i_memread_ex,
    input  logic [4:0] i_rd_ex,
    input  logic [4:0] i_rs1_id,
    input  logic [4:0] i_rs2_id,
    input  logic       i_use_rs1_id,
    input  logic       i_use_rs2_id,
    output logic       o_lu
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_use_rs1_id & (i_rs1_id == i_rd_ex);
    assign w_rs2_hit = i_use_rs2_id & (i_rs2_id == i_rd_ex);
    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign o_lu      = i_memread_ex & (i_rd_ex != REG_X0) & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch / load-use / memory-stall hazard controller for a 5-stage pipeline.
// Optional HAZARD_PERF_EN adds perf_lu_stalls, perf_redirects, perf_mem_waits.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int XLEN              = 32,
    parameter int INIT_FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_hazard_ctrl_if.master   bus,
    output hz_state_t              o_dbg_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]            perf_lu_stalls,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_mem_waits
`endif
);
    hz_state_t       r_state;
    hz_state_t       w_next_state;
    logic [3:0]      r_init_cnt;
    logic [XLEN-1:0] r_redirect_pc;
    hz_ctrl_t        w_ctrl;
    logic            w_redirect;
    logic            w_lu;
    logic            w_latch;
    logic            w_lu_stall;
    logic            w_frozen;

    load_use_detect u_load_use_detect (
        .i_memread_ex (bus.memread_ex),
        .i_rd_ex      (bus.rd_ex),
        .i_rs1_id     (bus.rs1_id),
        .i_rs2_id     (bus.rs2_id),
        .i_use_rs1_id (bus.use_rs1_id),
        .i_use_rs2_id (bus.use_rs2_id),
        .o_lu         (w_lu)
    );

    assign w_redirect = bus.branch_taken_ex | bus.jump_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_next_state;
    end

    // MEM_WAIT exits exactly like a RUN cycle, so both share one decode arm.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:     if (r_init_cnt == 4'd1) w_next_state = ST_RUN;
            ST_RUN,
            ST_MEM_WAIT: begin
                if (bus.mem_busy)    w_next_state = ST_MEM_WAIT;
                else if (w_redirect) w_next_state = ST_REDIRECT;
                else                 w_next_state = ST_RUN;
            end
            ST_REDIRECT: if (!bus.mem_busy) w_next_state = ST_RUN;
            default:     w_next_state = ST_INIT;
        endcase
    end

    always_comb begin
        w_ctrl     = CTRL_FREEZE;
        w_latch    = 1'b0;
        w_lu_stall = 1'b0;
        w_frozen   = 1'b0;
        case (r_state)
            ST_INIT: w_ctrl = CTRL_INIT;
            ST_RUN,
            ST_MEM_WAIT: begin
                if (bus.mem_busy) begin
                    w_frozen = 1'b1;
                end else if (w_redirect) begin
                    w_ctrl  = CTRL_REDIR_EX;
                    w_latch = 1'b1;
                end else if (w_lu) begin
                    w_ctrl     = CTRL_LU_STALL;
                    w_lu_stall = 1'b1;
                end else begin
                    w_ctrl = CTRL_RUN;
                end
            end
            ST_REDIRECT: begin
                if (bus.mem_busy) begin
                    w_ctrl   = CTRL_REDIR_HLD;
                    w_frozen = 1'b1;
                end else begin
                    w_ctrl = CTRL_REDIR_GO;
                end
            end
            default: w_ctrl = CTRL_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= 4'(INIT_FLUSH_CYCLES);
        end else if (r_state == ST_INIT && r_init_cnt != 4'd1) begin
            r_init_cnt <= r_init_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_redirect_pc <= '0;
        else if (w_latch) r_redirect_pc <= bus.target_pc_ex;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_lu;
    logic [31:0] r_perf_red;
    logic [31:0] r_perf_mw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_lu  <= '0;
            r_perf_red <= '0;
            r_perf_mw  <= '0;
        end else begin
            if (w_lu_stall) r_perf_lu  <= r_perf_lu + 32'd1;
            if (w_latch)    r_perf_red <= r_perf_red + 32'd1;
            if (w_frozen)   r_perf_mw  <= r_perf_mw + 32'd1;
        end
    end

    assign perf_lu_stalls = r_perf_lu;
    assign perf_redirects = r_perf_red;
    assign perf_mem_waits = r_perf_mw;
`endif

    assign bus.pc_write    = w_ctrl.pc_write;
    assign bus.ifid_write  = w_ctrl.ifid_write;
    assign bus.idex_write  = w_ctrl.idex_write;
    assign bus.exmem_write = w_ctrl.exmem_write;
    assign bus.ifid_flush  = w_ctrl.ifid_flush;
    assign bus.idex_flush  = w_ctrl.idex_flush;
    assign bus.pc_src      = w_ctrl.pc_src;
    assign bus.redirect_pc = r_redirect_pc;
    assign o_dbg_state     = r_state;
endmodule

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC and target buses.
REQ-002 SHALL have parameter INIT_FLUSH_CYCLES, default 2, number of flush cycles after reset release; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port branch_taken_ex  input  1  taken-branch decision of the instruction in EX, from the branch control unit.
REQ-006 SHALL have port jump_ex  input  1  JAL/JALR in EX.
REQ-007 SHALL have port target_pc_ex  input  XLEN  redirect target computed in EX.
REQ-008 SHALL have port memread_ex  input  1  EX instruction is a load.
REQ-009 SHALL have port rd_ex  input  5  destination register of EX instruction.
REQ-010 SHALL have ports rs1_id and rs2_id  input  5 each  source registers of ID instruction.
REQ-011 SHALL have ports use_rs1_id and use_rs2_id  input  1 each  ID instruction reads rs1 / rs2.
REQ-012 SHALL have port mem_busy  input  1  data memory not ready; the whole pipeline must freeze.
REQ-013 SHALL have ports pc_write, ifid_write, idex_write, exmem_write  output  1 each  stage-register enables.
REQ-014 SHALL have ports ifid_flush, idex_flush  output  1 each  synchronous bubble insert into IF/ID and ID/EX.
REQ-015 SHALL have ports pc_src  output  1  (1 = PC loads redirect_pc), and redirect_pc  output  XLEN  registered target.

Function
REQ-016 SHALL implement states INIT, RUN, REDIRECT, MEM_WAIT; control outputs are decoded from state and current inputs.
REQ-017 SHALL define redirect = branch_taken_ex | jump_ex, and lu = memread_ex & (rd_ex != 0) & ((use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex)).
REQ-018 SHALL apply priority in RUN as mem_busy > redirect > lu.
REQ-019 INIT SHALL drive pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_flush=1, pc_src=0, and decrement a 4-bit counter loaded with INIT_FLUSH_CYCLES; it SHALL go to RUN on the cycle the counter reaches 1; mem_busy SHALL be ignored in INIT.
REQ-020 RUN with no event SHALL drive all write enables 1, flushes 0, pc_src 0.
REQ-021 RUN with mem_busy=1 SHALL drive all write enables and flushes 0 and go to MEM_WAIT; redirect and lu SHALL NOT be evaluated that cycle.
REQ-022 RUN with redirect=1 SHALL drive pc_write=0, ifid_flush=1, idex_flush=1, exmem_write=1, latch target_pc_ex into redirect_pc, and go to REDIRECT.
REQ-023 REDIRECT SHALL drive pc_src=1, pc_write=1, ifid_flush=1, idex_flush=1, exmem_write=1; it SHALL then go to RUN, unless mem_busy=1, in which case all enables are 0 and the state stays REDIRECT.
REQ-024 RUN with lu=1 and no redirect SHALL drive pc_write=0, ifid_write=0, idex_flush=1, exmem_write=1, and stay in RUN (one bubble per hazard).
REQ-025 MEM_WAIT SHALL hold all enables 0 and flushes 0 while mem_busy=1, and return to RUN on the first cycle mem_busy=0, re-evaluating redirect/lu that cycle as in RUN.
REQ-026 Total taken-branch penalty SHALL be 2 bubbles; redirect_pc SHALL change only on REQ-022.
REQ-027 Redirect and lu in the same cycle SHALL resolve as a redirect only; no stall SHALL follow.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state INIT, load the counter with INIT_FLUSH_CYCLES, clear redirect_pc to 0, and clear all counters; outputs SHALL follow INIT decoding.
REQ-029 Reset asserted mid-REDIRECT or MEM_WAIT SHALL discard the pending operation.

Configuration
REQ-030 With HAZARD_PERF_EN defined, SHALL add outputs perf_lu_stalls, perf_redirects, perf_mem_waits (32 bits each, wrapping), incremented once per cycle of lu stall, per REQ-022 event, and per frozen cycle; without it, these ports and registers SHALL be absent.

Structure
REQ-031 State encoding and the x0 register index constant SHALL live in the shared defines file alongside the branch func3 codes.
REQ-032 Hazard detection (lu) SHALL be a combinational sub-module, load_use_detect.

Verification
REQ-033 Reset released with INIT_FLUSH_CYCLES=2 -> flushes=1 and enables=0 for exactly 2 cycles, then RUN with all enables=1.
REQ-034 branch_taken_ex=1, target 0x0000_0040 -> cycle N: pc_write=0, both flushes=1; cycle N+1: pc_src=1, redirect_pc=0x40, pc_write=1; cycle N+2: RUN.
REQ-035 memread_ex=1, rd_ex=5, rs2_id=5, use_rs2_id=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; rd_ex=0 with the same sources -> no stall.
REQ-036 Redirect and lu asserted together -> redirect sequence only, with no following stall cycle.
REQ-037 mem_busy=1 for 3 cycles during REDIRECT -> all enables stay 0 and pc_src=1 is held; after mem_busy falls -> one redirect cycle, then RUN.
REQ-038 rst_n pulsed low in MEM_WAIT (HAZARD_PERF_EN defined) -> immediate INIT, perf counters read 0, redirect_pc=0.
